// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor.
// Opcodes, operand/result widths, executor states and the divider step.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0] address_t;
    typedef logic signed [64:0] result;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef struct packed {
        result r;
        logic  err;
    } exec_result_t;

    typedef enum logic [2:0] {
        IDLE, FETCH, CAPT, EXEC, DIVW, WB, DONE
    } exec_state_t;

    localparam int DIV_CYCLES = 32;

    // One restoring step: returns {partial remainder, shifted quotient}.
    function automatic logic [64:0] div_step(
        input logic [32:0] rem,
        input logic [31:0] quo,
        input logic [31:0] dvs
    );
        logic [32:0] t;
        logic [31:0] nq;
        t  = {rem[31:0], quo[31]};
        nq = {quo[30:0], 1'b0};
        if (t >= {1'b0, dvs}) begin
            t     = t - {1'b0, dvs};
            nq[0] = 1'b1;
        end
        return {t, nq};
    endfunction

endpackage

// File: rtl/instr_exec_unit_if.sv
// Command, register-read and result-write bundle of the executor.
// master = controller/register side, slave = executor.
interface instr_exec_unit_if;
    import instr_register_pkg::*;

    logic         cmd_valid;
    logic         cmd_ready;
    address_t     cmd_first_ptr;
    logic [5:0]   cmd_count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_we;
    address_t     res_pointer;
    result        res_data;
    logic         res_err;
    logic         busy;
    logic         done;
    logic [5:0]   err_count;

    modport master (
        output cmd_valid, cmd_first_ptr, cmd_count, instruction_word,
        input  cmd_ready, read_pointer, res_we, res_pointer,
        input  res_data, res_err, busy, done, err_count
    );

    modport slave (
        input  cmd_valid, cmd_first_ptr, cmd_count, instruction_word,
        output cmd_ready, read_pointer, res_we, res_pointer,
        output res_data, res_err, busy, done, err_count
    );

endinterface

// File: rtl/instr_div_seq.sv
// Sequential restoring signed divider, one quotient bit per cycle.
// The start edge already performs the first step, so done rises DIV_CYCLES cycles after start.
module instr_div_seq
    import instr_register_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     start,
    input  operand_t dividend,
    input  operand_t divisor,
    output logic     done,
    output result    quotient,
    output result    remainder
);

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [32:0] rem;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    result       qx;
    result       rx;

    assign mag_a = dividend[31] ? -dividend : dividend;
    assign mag_b = divisor[31] ? -divisor : divisor;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            {rem, quo} <= div_step(33'd0, mag_a, mag_b);
            dvs        <= mag_b;
            cnt        <= 6'(DIV_CYCLES - 1);
            neg_q      <= dividend[31] ^ divisor[31];
            neg_r      <= dividend[31];
            done       <= 1'b0;
        end else if (cnt != 6'd0) begin
            {rem, quo} <= div_step(rem, quo, dvs);
            cnt        <= cnt - 6'd1;
            done       <= (cnt == 6'd1);
        end
    end

    // Magnitudes up to 2^31 fit unsigned in 32 bits; signs applied at 65 bits.
    assign qx        = {33'd0, quo};
    assign rx        = {32'd0, rem};
    assign quotient  = neg_q ? -qx : qx;
    assign remainder = neg_r ? -rx : rx;

endmodule

// File: rtl/instr_exec_unit.sv
// Walks a run of instruction-register slots, executes each and
// writes a 65-bit signed result plus error flag back per slot.
module instr_exec_unit
    import instr_register_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    instr_exec_unit_if.slave   bus
);

    exec_state_t  state;
    exec_state_t  state_n;
    address_t     ptr;
    address_t     res_ptr;
    logic [5:0]   remaining;
    logic [5:0]   err_cnt;
    instruction_t instr;
    exec_result_t ex;
    exec_result_t wb;
    logic         ex_div;
    logic         div_start;
    logic         div_done;
    result        div_q;
    result        div_r;
    result        a;
    result        b;

    instr_div_seq u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (instr.op_a),
        .divisor   (instr.op_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign a = 65'(instr.op_a);
    assign b = 65'(instr.op_b);

    always_comb begin
        ex     = '0;
        ex_div = 1'b0;
        unique case (instr.opc)
            ZERO:    ex.r = '0;
            PASSA:   ex.r = a;
            PASSB:   ex.r = b;
            ADD:     ex.r = a + b;
            SUB:     ex.r = a - b;
            MULT:    ex.r = a * b;
            DIV,
            MOD: begin
                if (instr.op_b == '0) ex.err = 1'b1;
                else                  ex_div = 1'b1;
            end
            default: ex.err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid)
                    state_n = (bus.cmd_count == 6'd0) ? DONE : FETCH;
            end
            FETCH: state_n = CAPT;
            CAPT:  state_n = EXEC;
            EXEC: begin
                if (ex_div) begin
                    div_start = 1'b1;
                    state_n   = DIVW;
                end else begin
                    state_n = WB;
                end
            end
            DIVW: if (div_done) state_n = WB;
            WB:   state_n = (remaining == 6'd1) ? DONE : FETCH;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr       <= '0;
            res_ptr   <= '0;
            remaining <= '0;
            err_cnt   <= '0;
            instr     <= '0;
            wb        <= '0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                ptr       <= bus.cmd_first_ptr;
                remaining <= bus.cmd_count;
                err_cnt   <= '0;
            end
            if (state == CAPT) instr <= bus.instruction_word;
            if (state == EXEC && !ex_div) wb <= ex;
            if (state == DIVW && div_done) begin
                wb.r   <= (instr.opc == MOD) ? div_r : div_q;
                wb.err <= 1'b0;
            end
            if (state_n == WB) res_ptr <= ptr;
            if (state == WB) begin
                ptr       <= ptr + 5'd1;
                remaining <= remaining - 6'd1;
                if (wb.err) err_cnt <= err_cnt + 6'd1;
            end
        end
    end

    assign bus.cmd_ready    = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.res_we       = (state == WB);
    assign bus.read_pointer = ptr;
    assign bus.res_pointer  = res_ptr;
    assign bus.res_data     = wb.r;
    assign bus.res_err      = wb.err;
    assign bus.err_count    = err_cnt;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: register-file model, per-slot schedule
// of expected writes, and a per-cycle compare on the falling edge.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    typedef struct {
        address_t     slot;
        exec_result_t e;
        int           cyc;
    } wb_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    instruction_t regs [32];
    wb_t          q [$];
    int           start_cyc = 1;
    int           done_cyc = 0;
    int           exp_errs = 0;
    address_t     hold_rp = '0;
    result        hold_rd = '0;

    instr_exec_unit_if bus ();

    instr_exec_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.instruction_word <= regs[bus.read_pointer];

    task automatic chk(input string n, input logic [64:0] act,
                       input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
        end
    endtask

    function automatic exec_result_t model(input instruction_t i);
        longint a;
        longint b;
        longint v;
        exec_result_t e;
        a = longint'(i.op_a);
        b = longint'(i.op_b);
        v = 0;
        e.err = 1'b0;
        case (int'(i.opc))
            0: v = 0;
            1: v = a;
            2: v = b;
            3: v = a + b;
            4: v = a - b;
            5: v = a * b;
            6: if (b == 0) e.err = 1'b1; else v = a / b;
            7: if (b == 0) e.err = 1'b1; else v = a % b;
            default: e.err = 1'b1;
        endcase
        e.r = 65'(v);
        return e;
    endfunction

    function automatic instruction_t mk(input opcode_t o, input int a,
                                        input int b);
        instruction_t x;
        x.opc  = o;
        x.op_a = a;
        x.op_b = b;
        return x;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        bit           bz;
        bit           we;
        int           t;
        int           ne;
        address_t     s;
        exec_result_t m;
        bit           isdiv;
        if (reset_n) begin
            bz = (cyc >= start_cyc) && (cyc <= done_cyc);
            chk("busy", bus.busy, bz);
            chk("cmd_ready", bus.cmd_ready, !bz);
            chk("done", bus.done, cyc == done_cyc);
            if (!bz || cyc == done_cyc)
                chk("err_count", bus.err_count, exp_errs);
            we = (q.size() > 0) && (q[0].cyc == cyc);
            chk("res_we", bus.res_we, we);
            if (we) begin
                hold_rp = q[0].slot;
                hold_rd = q[0].e.r;
                chk("res_err", bus.res_err, q[0].e.err);
                void'(q.pop_front());
            end
            chk("res_pointer", bus.res_pointer, hold_rp);
            chk("res_data", bus.res_data, hold_rd);
            if (bus.cmd_valid && !bz) begin
                start_cyc = cyc + 1;
                t  = start_cyc;
                ne = 0;
                for (int i = 0; i < int'(bus.cmd_count); i++) begin
                    s     = address_t'((int'(bus.cmd_first_ptr) + i) % 32);
                    m     = model(regs[s]);
                    isdiv = (int'(regs[s].opc) == 6 || int'(regs[s].opc) == 7)
                            && !m.err;
                    q.push_back('{slot: s, e: m,
                                  cyc: t + 3 + (isdiv ? DIV_CYCLES : 0)});
                    t  = t + 4 + (isdiv ? DIV_CYCLES : 0);
                    ne = ne + int'(m.err);
                end
                done_cyc = t;
                exp_errs = ne;
            end
        end
    end

    task automatic run_cmd(input address_t f, input logic [5:0] n,
                           input bit poke);
        @(posedge clk);
        #1;
        bus.cmd_first_ptr = f;
        bus.cmd_count     = n;
        bus.cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (poke) begin
            @(posedge clk);
            #1;
            bus.cmd_valid     = 1'b1;
            bus.cmd_first_ptr = 5'd17;
            bus.cmd_count     = 6'd5;
            repeat (2) @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
        end
        while (cyc <= done_cyc) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        start_cyc = 1;
        done_cyc  = 0;
        exp_errs  = 0;
        hold_rp   = '0;
        hold_rd   = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        instruction_t x;
        logic [5:0]   n;
        bus.cmd_valid     = 1'b0;
        bus.cmd_first_ptr = '0;
        bus.cmd_count     = '0;
        for (int i = 0; i < 32; i++) regs[i] = mk(PASSA, i, -i);

        chk("model_add", model(mk(ADD, -5, 7)).r, 65'd2);
        chk("model_mult", model(mk(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF)).r,
            65'h0_3FFF_FFFF_0000_0001);
        chk("model_sub", model(mk(SUB, 32'h8000_0000, 1)).r,
            65'h1_FFFF_FFFF_7FFF_FFFF);
        chk("model_div", model(mk(DIV, -7, 2)).r, 65'h1_FFFF_FFFF_FFFF_FFFD);
        chk("model_mod", model(mk(MOD, -7, 2)).r, 65'h1_FFFF_FFFF_FFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_data", bus.res_data, 65'd0);

        regs[3] = mk(ADD, -5, 7);
        run_cmd(5'd3, 6'd1, 1'b0);
        chk("add_data", bus.res_data, 65'd2);
        chk("add_ptr", bus.res_pointer, 5'd3);

        regs[5] = mk(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_cmd(5'd5, 6'd1, 1'b0);
        chk("mult_data", bus.res_data, 65'h0_3FFF_FFFF_0000_0001);
        regs[6] = mk(SUB, 32'h8000_0000, 1);
        run_cmd(5'd6, 6'd1, 1'b0);
        chk("sub_data", bus.res_data, 65'h1_FFFF_FFFF_7FFF_FFFF);

        regs[30] = mk(ADD, 1, 2);
        regs[31] = mk(PASSB, 9, -3);
        regs[0]  = mk(SUB, 10, 4);
        run_cmd(5'd30, 6'd3, 1'b0);
        chk("wrap_ptr", bus.res_pointer, 5'd0);
        chk("wrap_data", bus.res_data, 65'd6);

        regs[8] = mk(DIV, -7, 2);
        run_cmd(5'd8, 6'd1, 1'b0);
        chk("div_data", bus.res_data, 65'h1_FFFF_FFFF_FFFF_FFFD);
        regs[9] = mk(MOD, -7, 2);
        run_cmd(5'd9, 6'd1, 1'b0);
        chk("mod_data", bus.res_data, 65'h1_FFFF_FFFF_FFFF_FFFF);
        regs[10] = mk(DIV, 32'h8000_0000, -1);
        run_cmd(5'd10, 6'd1, 1'b0);
        chk("divmin_data", bus.res_data, 65'h0_0000_0000_8000_0000);
        chk("divmin_err", bus.res_err, 1'b0);

        regs[0] = mk(DIV, 123, 0);
        x = {4'hF, 64'd0};
        x.op_a = 77;
        regs[1] = x;
        run_cmd(5'd0, 6'd2, 1'b1);
        chk("err_cnt2", bus.err_count, 6'd2);
        chk("err_flag", bus.res_err, 1'b1);
        chk("err_data", bus.res_data, 65'd0);

        run_cmd(5'd4, 6'd0, 1'b0);

        regs[12] = mk(DIV, 1000, 7);
        @(posedge clk);
        #1;
        bus.cmd_first_ptr = 5'd12;
        bus.cmd_count     = 6'd1;
        bus.cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_err", bus.err_count, 6'd0);

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 32; i++)
                regs[i] = {4'($urandom_range(0, 15)), rnd_op(), rnd_op()};
            n = ($urandom_range(0, 6) == 0) ? 6'd32
                                             : 6'($urandom_range(0, 12));
            run_cmd(5'($urandom_range(0, 31)), n, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Reader/executor on the far side of the instruction register. The register's write side loads opcode/operand entries; this block reads them back out.
- On a command it walks a run of register slots. For each slot it fetches the instruction_t, computes the signed result per opcode, and writes a 65-bit result plus an error flag back to the result store for that slot.
- Sits between the testbench/controller command interface and the register's read port and result-write port.

Parameters:
- DIV_CYCLES, 32, iterations of the sequential divider (one per quotient bit; fixed to operand width).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_first_ptr  input  5 (address_t)  first slot to execute.
- cmd_count  input  6  number of slots, 0..32.
- read_pointer  output  5 (address_t)  register read address.
- instruction_word  input  instruction_t  register read data, valid the cycle after read_pointer is presented.
- res_we  output  1  one-cycle result write strobe.
- res_pointer  output  5 (address_t)  slot being written.
- res_data  output  65 (result)  computed result.
- res_err  output  1  error for this slot (qualified by res_we).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of command.
- err_count  output  6  errors in last command; cleared on accept.

Behaviour:
- Reset values (reset_n low at clk edge):
  - State = IDLE; all outputs 0 except cmd_ready = 1.
  - Divider aborted; no res_we is issued afterwards for the aborted slot.
- States: IDLE, FETCH, CAPT, EXEC, DIVW, WB, DONE.
- IDLE:
  - On accept, latch ptr = cmd_first_ptr, remaining = cmd_count, clear err_count.
  - Go to FETCH, or to DONE if cmd_count = 0.
  - cmd_valid outside IDLE is ignored; no queueing.
- FETCH: drive read_pointer = ptr -> CAPT.
- CAPT: latch instruction_word into an internal copy -> EXEC.
- EXEC:
  - ZERO: 0.
  - PASSA / PASSB: op_a / op_b sign-extended to 65 bits.
  - ADD / SUB: 65-bit signed, with operands sign-extended first, so no overflow is possible.
  - MULT: 64-bit signed product, sign-extended to 65 bits.
  - Single-cycle opcodes -> WB.
  - DIV / MOD with op_b != 0: start divider -> DIVW.
  - DIV / MOD with op_b = 0: result 0, err = 1 -> WB.
  - opc values 8..15: result 0, err = 1 -> WB.
- DIVW: wait for divider done, exactly DIV_CYCLES cycles after start -> WB.
- Division semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend (SystemVerilog / and % semantics).
  - -2^31 / -1 = +2^31, representable in 65 bits, no error.
- WB:
  - res_we = 1 with res_pointer = ptr, res_data, res_err.
  - err_count increments on err.
  - ptr increments modulo 32 (31 wraps to 0); remaining decrements.
  - remaining = 0 -> DONE, else FETCH.
- DONE: done = 1 for one cycle -> IDLE.
- Latency:
  - Non-divide slot: 4 cycles, FETCH to WB inclusive.
  - DIV / MOD slot: 4 + DIV_CYCLES = 36 cycles.
  - count = 32 visits every slot exactly once.
- res_data and res_pointer hold their last value between strobes.

Decomposition:
- instr_register_pkg (shared):
  - existing: opcode_t, operand_t, address_t, result, instruction_t.
  - add: exec_state_t enum, DIV_CYCLES constant, and an exec_result_t struct {result r; logic err;}.
- Sub-module instr_div_seq:
  - Restoring signed divider with inputs start/dividend/divisor and outputs done/quotient/remainder.
  - Synchronous active-low reset on the same clk.
  - Operates on magnitudes, then applies signs.

Test Plan:
- ADD, slot 3: op_a = -5, op_b = 7, cmd_first_ptr = 3, count = 1 -> single res_we at res_pointer 3, res_data = 2, res_err = 0; done 5 cycles after accept; err_count = 0.
- MULT: 0x7FFFFFFF * 0x7FFFFFFF -> res_data = 65'h0_3FFFFFFF_00000001. SUB: -2^31 - 1 -> res_data = -2147483649 in 65 bits.
- Wrap: first_ptr = 30, count = 3 -> res_pointer sequence 30, 31, 0; one done pulse after the third write.
- DIV: -7 / 2 -> -3 and MOD: -7 % 2 -> -1, each with res_we 36 cycles after FETCH. -2^31 / -1 -> +2147483648, err = 0.
- Errors: DIV by 0 and opc = 4'hF in slots 0 and 1, count = 2 -> both res_data = 0, res_err = 1; err_count = 2. cmd_valid pulsed while busy -> ignored, cmd_ready = 0.
- Reset mid-divide: reset_n low 10 cycles into DIVW -> next edge state IDLE, cmd_ready = 1, busy = 0, no res_we or done emitted. cmd_count = 0 -> done pulse, no res_we.
